// File: rtl/fxd_pkg.sv
// rtl/fxd_pkg.sv - FP32 field widths, pipeline latency and unpacked-float type
package fxd_pkg;

    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    localparam int EXP_BIAS = 127;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exponent;
        logic [MAN_W:0]   mantissa;
        logic             is_zero;
        logic             is_nan;
        logic             is_inf;
    } fp_unpacked_t;

endpackage

// File: rtl/fp32_unpack.sv
// rtl/fp32_unpack.sv - combinational FP32 unpack/classify, denormals flushed to zero
module fp32_unpack
    import fxd_pkg::*;
(
    input  logic [31:0]  dataa_i,
    output fp_unpacked_t fp_o
);

    logic [EXP_W-1:0] exp_f;
    logic [MAN_W-1:0] frac_f;

    assign exp_f  = dataa_i[30 -: EXP_W];
    assign frac_f = dataa_i[MAN_W-1:0];

    always_comb begin
        fp_o          = '0;
        fp_o.sign     = dataa_i[31];
        fp_o.exponent = exp_f;
        fp_o.is_zero  = (exp_f == '0);
        fp_o.is_nan   = (exp_f == '1) && (frac_f != '0);
        fp_o.is_inf   = (exp_f == '1) && (frac_f == '0);
        fp_o.mantissa = fp_o.is_zero ? '0 : {1'b1, frac_f};
    end

endmodule

// File: rtl/float_to_fxd_pipe.sv
// rtl/float_to_fxd_pipe.sv - 3-stage FP32 to Q1.FRAC_W of |x-OFFSET|/2^DIV_SHIFT; FXD_SATURATE_EN saturates overflow
module float_to_fxd_pipe
    import fxd_pkg::*;
#(
    parameter int FRAC_W    = 20,
    parameter int OFFSET    = 128,
    parameter int DIV_SHIFT = 7
)(
    input  logic            clk,
    input  logic            reset,
    input  logic            clk_en,
    input  logic            start,
    input  logic [31:0]     dataa,
    output logic            done,
    output logic [FRAC_W:0] result,
    output logic            err
);

    localparam int W     = FRAC_W + 1;
    // Magnitude is held with one guard bit below the result LSB; assumes FRAC_W+1 >= DIV_SHIFT.
    localparam int F     = FRAC_W - DIV_SHIFT + 1;
    localparam int A_RAW = W + 18;
    localparam int A     = (A_RAW > MAN_W + 3) ? A_RAW : MAN_W + 3;
    localparam logic [A-1:0] OFF_U = A'(OFFSET) << F;
    localparam logic [A:0]   ONE_A = {{A{1'b0}}, 1'b1};

    fp_unpacked_t          unpack_fp;
    fp_unpacked_t          s1_q;
    logic [PIPE_LAT-1:0]   vld_q;
    logic [A-1:0]          mag_q, mag_d;
    logic                  big_q, big_d;
    logic                  special_q;
    logic [W-1:0]          result_q, result_d;
    logic                  err_q, err_d;

    logic [A-1:0]          m_ext, xt, lost;
    logic                  sticky, ge_off, ovf;
    logic [A:0]            rnd;
    int                    sh;

    fp32_unpack u_unpack (
        .dataa_i (dataa),
        .fp_o    (unpack_fp)
    );

    // S2: xt = floor(|x| * 2^F); magnitude kept modulo 2^A, big_d marks values far past range.
    always_comb begin
        m_ext = A'(s1_q.mantissa);
        sh    = int'(s1_q.exponent) - (EXP_BIAS + MAN_W) + F;
        if (sh >= 0) begin
            xt   = m_ext << sh;
            lost = '0;
        end else begin
            xt   = m_ext >> (-sh);
            lost = m_ext & ~({A{1'b1}} << (-sh));
        end
        sticky = |lost;
        big_d  = !s1_q.is_zero && (sh >= A - 1 - MAN_W);
        ge_off = big_d || (xt >= OFF_U);
        if (s1_q.sign)
            mag_d = xt + OFF_U;
        else if (ge_off)
            mag_d = xt - OFF_U;
        else
            mag_d = OFF_U - xt - A'(sticky);
    end

    // S3: with one guard bit, floor(v + 0.5) reduces to (mag + 1) >> 1 exactly.
    assign rnd = ({1'b0, mag_q} + ONE_A) >> 1;
    assign ovf = big_q || (rnd[A:W] != '0);

    always_comb begin
        result_d = rnd[W-1:0];
        err_d    = 1'b0;
        if (special_q) begin
            result_d = '1;
            err_d    = 1'b1;
        end else if (ovf) begin
`ifdef FXD_SATURATE_EN
            result_d = '1;
`else
            result_d = rnd[W-1:0];
`endif
            err_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q     <= '0;
            s1_q      <= '0;
            mag_q     <= '0;
            big_q     <= 1'b0;
            special_q <= 1'b0;
            result_q  <= '0;
            err_q     <= 1'b0;
        end else if (clk_en) begin
            vld_q <= {vld_q[PIPE_LAT-2:0], start};
            if (start)
                s1_q <= unpack_fp;
            if (vld_q[0]) begin
                mag_q     <= mag_d;
                big_q     <= big_d;
                special_q <= s1_q.is_nan | s1_q.is_inf;
            end
            if (vld_q[1]) begin
                result_q <= result_d;
                err_q    <= err_d;
            end
        end
    end

    assign done   = vld_q[PIPE_LAT-1];
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_float_to_fxd_pipe.sv
// tb/tb_float_to_fxd_pipe.sv - directed self-checking bench for float_to_fxd_pipe
module tb_float_to_fxd_pipe;

    localparam int W  = 21;
    localparam int WP = 17;

`ifdef FXD_SATURATE_EN
    localparam logic [31:0] OVF_384 = 32'h1FFFFF;
    localparam logic [31:0] OVF_BIG = 32'h1FFFFF;
`else
    localparam logic [31:0] OVF_384 = 32'h000000;
    localparam logic [31:0] OVF_BIG = 32'h100000;
`endif

    logic          clk = 1'b0;
    logic          reset, clk_en, start;
    logic [31:0]   dataa;
    logic          done, err, done_p, err_p;
    logic [W-1:0]  result;
    logic [WP-1:0] result_p;
    int            n_checks = 0;
    int            n_errors = 0;

    always #5 clk = ~clk;

    float_to_fxd_pipe dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
        .done(done), .result(result), .err(err)
    );

    float_to_fxd_pipe #(.FRAC_W(16), .OFFSET(64), .DIV_SHIFT(6)) dut_p (
        .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
        .done(done_p), .result(result_p), .err(err_p)
    );

    logic [31:0] b2b_in  [12] = '{32'h41C8CCCD, 32'h42FB0000, 32'h437B0000, 32'h437F0000,
                                  32'h00000000, 32'h00000001, 32'hBF800000, 32'h43000004,
                                  32'h43000001, 32'h42FFFFFF, 32'h42FFFFFC, 32'h42FFFFF8};
    logic [31:0] b2b_exp [12] = '{32'h0CDCCD, 32'h005000, 32'h0F6000, 32'h0FE000,
                                  32'h100000, 32'h100000, 32'h102000, 32'h000001,
                                  32'h000000, 32'h000000, 32'h000000, 32'h000001};

    logic [31:0] one_in  [9] = '{32'h42FB0000, 32'h437F0000, 32'h00000000, 32'h43C00000,
                                 32'h7149F2CA, 32'h7FC00000, 32'hFF800000, 32'h7F800000,
                                 32'h00000001};
    logic [31:0] one_exp [9] = '{32'h005000, 32'h0FE000, 32'h100000, OVF_384,
                                 OVF_BIG, 32'h1FFFFF, 32'h1FFFFF, 32'h1FFFFF,
                                 32'h100000};
    logic        one_err [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [31:0] v, output int lat);
        @(negedge clk);
        start = 1'b1;
        dataa = v;
        lat   = 0;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int lat;
        int pulses;

        reset  = 1'b1;
        clk_en = 1'b1;
        start  = 1'b0;
        dataa  = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_done_p", done_p, 0);

        // start in the very first cycle after reset release
        @(negedge clk);
        reset = 1'b0;
        start = 1'b1;
        dataa = 32'h41C8CCCD;
        lat   = 0;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        chk("first_lat", lat, 3);
        chk("first_res", result, 32'h0CDCCD);
        chk("first_err", err, 0);

        for (int i = 0; i < 9; i++) begin
            issue(one_in[i], lat);
            chk($sformatf("one%0d_lat", i), lat, 3);
            chk($sformatf("one%0d_res", i), result, one_exp[i]);
            chk($sformatf("one%0d_err", i), err, one_err[i]);
        end

        @(negedge clk);
        chk("hold_done_low", done, 0);
        repeat (3) @(negedge clk);
        chk("hold_res", result, 32'h100000);
        chk("hold_err", err, 0);

        pulses = 0;
        for (int j = 0; j < 17; j++) begin
            @(negedge clk);
            if (done) pulses++;
            if (j >= 3 && j < 15) begin
                chk($sformatf("b2b%0d_done", j - 3), done, 1);
                chk($sformatf("b2b%0d_res", j - 3), result, b2b_exp[j - 3]);
                chk($sformatf("b2b%0d_err", j - 3), err, 0);
            end else begin
                chk($sformatf("b2b_idle%0d", j), done, 0);
            end
            if (j < 12) begin
                start = 1'b1;
                dataa = b2b_in[j];
            end else begin
                start = 1'b0;
            end
        end
        chk("b2b_pulses", pulses, 12);

        @(negedge clk);
        start = 1'b1;
        dataa = 32'h437B0000;
        lat   = 0;
        @(negedge clk);
        start  = 1'b0;
        lat    = 1;
        @(negedge clk);
        lat    = 2;
        clk_en = 1'b0;
        repeat (5) begin
            @(negedge clk);
            lat++;
            chk($sformatf("frz_done_l%0d", lat), done, 0);
        end
        clk_en = 1'b1;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("frz_lat", lat, 8);
        chk("frz_res", result, 32'h0F6000);

        issue(32'h42000000, lat);
        chk("par_lat", lat, 3);
        chk("par_res_def", result, 32'h0C0000);
        chk("par_done_p", done_p, 1);
        chk("par_res_p", result_p, 32'h08000);
        chk("par_err_p", err_p, 0);

        issue(32'h437B0000, lat);
        chk("pre_rst_res", result, 32'h0F6000);
        @(negedge clk);
        start = 1'b1;
        dataa = 32'h437F0000;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rst2_done", done, 0);
        chk("rst2_res", result, 0);
        chk("rst2_err", err, 0);
        chk("rst2_res_p", result_p, 0);
        reset  = 1'b0;
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("rst2_pulses", pulses, 0);
        chk("rst2_res_after", result, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/float_to_fxd_pipe.md
FLOAT_TO_FXD_PIPE -- requirements
Module: float_to_fxd_pipe

Interface
REQ-001 SHALL have parameter FRAC_W, default 20: fractional bits of result; result width W = FRAC_W+1 (unsigned Q1.FRAC_W).
REQ-002 SHALL have parameter OFFSET, default 128: integer subtracted from input; legal range 0..65535.
REQ-003 SHALL have parameter DIV_SHIFT, default 7: divisor is 2^DIV_SHIFT; legal range 0..15.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port clk_en  input  1  clock enable; low freezes all state.
REQ-007 SHALL have port start  input  1  one-cycle pulse; dataa valid this cycle.
REQ-008 SHALL have port dataa  input  32  IEEE-754 single-precision operand x.
REQ-009 SHALL have port done  output  1  one-cycle pulse; result/err valid this cycle.
REQ-010 SHALL have port result  output  W  round(|x - OFFSET| / 2^DIV_SHIFT) in units of 2^-FRAC_W.
REQ-011 SHALL have port err  output  1  overflow, NaN or Inf on the transaction marked by done.

Function
REQ-012 SHALL be a 3-stage pipeline: S1 unpack/classify, S2 align+subtract+abs, S3 scale+round+range check.
REQ-013 SHALL assert done exactly 3 clk_en-qualified cycles after the accepted start; one start per cycle accepted, no back-pressure.
REQ-014 SHALL hold result and err stable from one done to the next; done is high for a single enabled cycle.
REQ-015 SHALL compute v = |x - OFFSET| * 2^(FRAC_W - DIV_SHIFT) from the exact float value, result = floor(v + 0.5) (round half up), bit-exact with no intermediate truncation error (guard plus sticky bits kept as needed).
REQ-016 SHALL treat sign correctly: negative x yields |x| + OFFSET before scaling.
REQ-017 SHALL flush denormals and +/-0 to x = 0 (result = OFFSET/2^DIV_SHIFT scaled, err = 0).
REQ-018 SHALL on NaN or +/-Inf force result to all-ones and err = 1, regardless of configuration.
REQ-019 SHALL define overflow as rounded result >= 2^W; handling per REQ-024/REQ-025.
REQ-020 SHALL, when clk_en = 0, ignore start and freeze every pipeline register, done included.

Reset
REQ-021 SHALL on reset clear all pipeline valid bits, done = 0, result = 0, err = 0, asynchronously.
REQ-022 SHALL discard in-flight transactions on reset; no done pulse for operations started before reset.
REQ-023 SHALL accept a start in the first enabled cycle after reset deassertion.

Configuration
REQ-024 SHALL, with FXD_SATURATE_EN defined, saturate overflow to result all-ones with err = 1.
REQ-025 SHALL, without FXD_SATURATE_EN, output the low W bits of the rounded value (modulo 2^W) with err = 1 on overflow.

Structure
REQ-026 SHALL take from shared package fxd_pkg: FP32 field widths (EXP_W 8, MAN_W 23), EXP_BIAS 127, PIPE_LAT 3, and the unpacked-float struct typedef (sign, exponent, mantissa with hidden bit, is_zero, is_nan, is_inf).
REQ-027 SHALL instantiate one sub-module fp32_unpack (combinational, S1 classification) and keep alignment/rounding in the top.

Verification
REQ-028 SHALL check defaults: dataa 0x41C8CCCD (25.1) -> result 0x0CDCCD, 0x42FB0000 (125.5) -> 0x005000, 0x437B0000 (251.0) -> 0x0F6000, 0x437F0000 (255.0) -> 0x0FE000, 0x00000000 -> 0x100000, all err = 0.
REQ-029 SHALL check back-to-back starts on 12 consecutive cycles -> 12 done pulses, each 3 cycles after its start, in order, with correct results.
REQ-030 SHALL check overflow: dataa 0x43C00000 (384.0) -> err = 1, result 0x1FFFFF with FXD_SATURATE_EN, 0x000000 without.
REQ-031 SHALL check specials: 0x7FC00000 (NaN) and 0xFF800000 (-Inf) -> result 0x1FFFFF, err = 1; 0x00000001 (denormal) -> 0x100000, err = 0.
REQ-032 SHALL check control: clk_en low for 5 cycles mid-flight delays done by exactly 5 cycles; reset 1 cycle after start -> no done, outputs 0.
REQ-033 SHALL check parameters FRAC_W 16, OFFSET 64, DIV_SHIFT 6: dataa 0x42000000 (32.0) -> result 0x08000, err = 0.
